// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with occupancy flags, sticky overflow/underflow and a registered count.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered 1-cycle read data.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Flags depend only on the registered count, so requests never reach them combinationally.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = w_en & ~full;
    assign rd_acc = r_en & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (w_en & full);
        underflow_d = underflow_q | (r_en & empty);
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (rd_acc) data_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign data_out = data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default parameters: fill, drain, wrap, collisions, reset.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_param dut (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .r_en         (r_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        w_en = w;
        r_en = r;
        data_in = d;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Read one word and check it; FWFT shows the head before the pop, standard mode after.
    task automatic pop_check(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        check(tag, data_out, exp);
        step(1'b0, 1'b1, 8'h00);
`else
        step(1'b0, 1'b1, 8'h00);
        check(tag, data_out, exp);
`endif
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_d;
        int exp_cnt;

        do_reset();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        check("rst_dout", data_out, 0);

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            check("fill_count", count, i + 1);
            check("fill_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
            check("fill_full", full, (i + 1 == 16) ? 1 : 0);
        end
        step(1'b1, 1'b0, 8'hFF);
        check("ovf_count", count, 16);
        check("ovf_flag", overflow, 1);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            pop_check("drain_data", 8'(i));
            exp_cnt = 15 - i;
            check("drain_count", count, exp_cnt);
            check("drain_aempty", almost_empty, (exp_cnt <= 2) ? 1 : 0);
            check("drain_empty", empty, (exp_cnt == 0) ? 1 : 0);
        end
        step(1'b0, 1'b1, 8'h00);
        check("unf_flag", underflow, 1);
        check("unf_count", count, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("unf_hold", data_out, 8'h0F);
`endif

        // Wrap-around with occupancy held at 3
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 8'(8'h80 + k));
            q.push_back(8'(8'h80 + k));
        end
        for (int k = 0; k < 40; k++) begin
            exp_d = q.pop_front();
            q.push_back(8'(8'h90 + k));
`ifdef SYNC_FIFO_FWFT_EN
            check("wrap_data", data_out, exp_d);
            step(1'b1, 1'b1, 8'(8'h90 + k));
`else
            step(1'b1, 1'b1, 8'(8'h90 + k));
            check("wrap_data", data_out, exp_d);
`endif
            check("wrap_count", count, 3);
        end
        check("wrap_ovf", overflow, 0);
        check("wrap_unf", underflow, 0);

        // Simultaneous read/write while full
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b1, 1'b1, 8'hEE);
        check("full_rw_count", count, 15);
        check("full_rw_ovf", overflow, 1);
`ifndef SYNC_FIFO_FWFT_EN
        check("full_rw_data", data_out, 8'h40);
`endif
        for (int i = 1; i < 16; i++) pop_check("full_rw_drain", 8'(8'h40 + i));
        check("full_rw_empty", empty, 1);

        // Simultaneous read/write while empty
        do_reset();
        step(1'b1, 1'b1, 8'hA5);
        check("empty_rw_count", count, 1);
        check("empty_rw_unf", underflow, 1);
        pop_check("empty_rw_data", 8'hA5);
        check("empty_rw_after", count, 0);

        // Mid-operation reset with a write in the same cycle
        do_reset();
        step(1'b0, 1'b1, 8'h00);
        check("mid_unf_pre", underflow, 1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        check("mid_count_pre", count, 9);
        rst = 1'b1;
        w_en = 1'b1;
        data_in = 8'hEE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        w_en = 1'b0;
        check("mid_count", count, 0);
        check("mid_empty", empty, 1);
        check("mid_ovf", overflow, 0);
        check("mid_unf", underflow, 0);
        step(1'b1, 1'b0, 8'h77);
        pop_check("mid_newdata", 8'h77);
        check("mid_final_count", count, 0);

`ifdef SYNC_FIFO_FWFT_EN
        do_reset();
        step(1'b1, 1'b0, 8'h3C);
        check("fwft_empty", empty, 0);
        check("fwft_data", data_out, 8'h3C);
        step(1'b0, 1'b1, 8'h00);
        check("fwft_pop_empty", empty, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
